// File: rtl/mdio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_responder
//  Description : Clause-22 MDIO management responder (PHY side). Oversamples
//                MDC/MDIO on the system clock, decodes read/write frames and
//                talks to the local register bank through one-cycle strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter bit         BCAST_EN     = 1'b1,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        clk_25mhz,
    input  logic        reset_n,
    input  logic        mdc,
    input  logic        mdi,
    output logic        mdo,
    output logic        mdo_en,
    output logic [4:0]  reg_addr,
    output logic        reg_rd_stb,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr_stb,
    output logic [15:0] reg_wdata,
    output logic        frame_err
);

    localparam logic [5:0] c_pre_len = 6'(PREAMBLE_LEN);
    localparam logic [5:0] c_pre_max = 6'd32;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ST    = 4'd1,
        S_OP    = 4'd2,
        S_PHYAD = 4'd3,
        S_REGAD = 4'd4,
        S_TA    = 4'd5,
        S_RDATA = 4'd6,
        S_WDATA = 4'd7,
        S_SKIP  = 4'd8
    } state_t;

    // Synchronisers and edge history
    logic        r_mdc_s1, r_mdc_s2, r_mdc_d;
    logic        r_mdi_s1, r_mdi_s2;
    logic        w_rise;
    logic        w_bit;

    // Frame state
    state_t      r_state, w_state_next;
    logic [5:0]  r_pre_cnt, w_pre_next;
    logic [4:0]  r_bit_cnt, w_bit_next;
    logic [14:0] r_sh, w_sh_next;
    logic        r_op_read, w_op_read_next;
    logic        r_match, w_match_next;
    logic [15:0] r_tx, w_tx_next;
    logic        r_cap;
    logic [4:0]  w_field;

    // Registered outputs
    logic        r_mdo, w_mdo_next;
    logic        r_mdo_en, w_mdo_en_next;
    logic [4:0]  r_reg_addr, w_reg_addr_next;
    logic        r_rd_stb, w_rd_stb_next;
    logic        r_wr_stb, w_wr_stb_next;
    logic [15:0] r_wdata, w_wdata_next;
    logic        r_err, w_err_next;

    assign w_rise  = r_mdc_s2 & ~r_mdc_d;
    assign w_bit   = r_mdi_s2;
    assign w_field = {r_sh[3:0], w_bit};

    assign mdo        = r_mdo;
    assign mdo_en     = r_mdo_en;
    assign reg_addr   = r_reg_addr;
    assign reg_rd_stb = r_rd_stb;
    assign reg_wr_stb = r_wr_stb;
    assign reg_wdata  = r_wdata;
    assign frame_err  = r_err;

    // Two-flop synchronisers for MDC/MDIO plus the delayed MDC for rise detect
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            r_mdc_s1 <= 1'b0;
            r_mdc_s2 <= 1'b0;
            r_mdc_d  <= 1'b0;
            r_mdi_s1 <= 1'b0;
            r_mdi_s2 <= 1'b0;
        end else begin
            r_mdc_s1 <= mdc;
            r_mdc_s2 <= r_mdc_s1;
            r_mdc_d  <= r_mdc_s2;
            r_mdi_s1 <= mdi;
            r_mdi_s2 <= r_mdi_s1;
        end
    end

    // State register and all frame/output registers
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_pre_cnt  <= 6'd0;
            r_bit_cnt  <= 5'd0;
            r_sh       <= 15'd0;
            r_op_read  <= 1'b0;
            r_match    <= 1'b0;
            r_tx       <= 16'd0;
            r_cap      <= 1'b0;
            r_mdo      <= 1'b0;
            r_mdo_en   <= 1'b0;
            r_reg_addr <= 5'd0;
            r_rd_stb   <= 1'b0;
            r_wr_stb   <= 1'b0;
            r_wdata    <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pre_cnt  <= w_pre_next;
            r_bit_cnt  <= w_bit_next;
            r_sh       <= w_sh_next;
            r_op_read  <= w_op_read_next;
            r_match    <= w_match_next;
            r_tx       <= w_tx_next;
            r_cap      <= r_rd_stb;
            r_mdo      <= w_mdo_next;
            r_mdo_en   <= w_mdo_en_next;
            r_reg_addr <= w_reg_addr_next;
            r_rd_stb   <= w_rd_stb_next;
            r_wr_stb   <= w_wr_stb_next;
            r_wdata    <= w_wdata_next;
            r_err      <= w_err_next;
        end
    end

    // Frame decoder: everything advances only on a detected MDC rise,
    // except the read-data capture which follows the read strobe by a cycle
    always_comb begin
        w_state_next    = r_state;
        w_pre_next      = r_pre_cnt;
        w_bit_next      = r_bit_cnt;
        w_sh_next       = r_sh;
        w_op_read_next  = r_op_read;
        w_match_next    = r_match;
        w_tx_next       = r_tx;
        w_mdo_next      = r_mdo;
        w_mdo_en_next   = r_mdo_en;
        w_reg_addr_next = r_reg_addr;
        w_wdata_next    = r_wdata;
        w_rd_stb_next   = 1'b0;
        w_wr_stb_next   = 1'b0;
        w_err_next      = 1'b0;

        if (r_cap) begin
            w_tx_next = reg_rdata;
        end

        if (w_rise) begin
            case (r_state)
                S_IDLE: begin
                    if (w_bit) begin
                        if (r_pre_cnt != c_pre_max) begin
                            w_pre_next = r_pre_cnt + 6'd1;
                        end
                    end else begin
                        // This 0 is the first start bit when preamble was long enough
                        w_pre_next = 6'd0;
                        if (r_pre_cnt >= c_pre_len) begin
                            w_state_next = S_ST;
                        end
                    end
                end
                S_ST: begin
                    w_bit_next = 5'd0;
                    if (w_bit) begin
                        w_state_next = S_OP;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_OP: begin
                    if (r_bit_cnt == 5'd0) begin
                        w_sh_next  = {r_sh[13:0], w_bit};
                        w_bit_next = 5'd1;
                    end else begin
                        w_bit_next = 5'd0;
                        case ({r_sh[0], w_bit})
                            2'b10: begin
                                w_op_read_next = 1'b1;
                                w_state_next   = S_PHYAD;
                            end
                            2'b01: begin
                                w_op_read_next = 1'b0;
                                w_state_next   = S_PHYAD;
                            end
                            default: begin
                                w_err_next   = 1'b1;
                                w_state_next = S_IDLE;
                            end
                        endcase
                    end
                end
                S_PHYAD: begin
                    w_sh_next = {r_sh[13:0], w_bit};
                    if (r_bit_cnt == 5'd4) begin
                        // Broadcast address only ever accepts writes
                        w_match_next = (w_field == PHY_ADDR) ||
                                       (BCAST_EN && !r_op_read && (w_field == 5'd0));
                        w_bit_next   = 5'd0;
                        w_state_next = S_REGAD;
                    end else begin
                        w_bit_next = r_bit_cnt + 5'd1;
                    end
                end
                S_REGAD: begin
                    w_sh_next = {r_sh[13:0], w_bit};
                    if (r_bit_cnt == 5'd4) begin
                        w_reg_addr_next = w_field;
                        w_bit_next      = 5'd0;
                        if (r_match) begin
                            w_rd_stb_next = r_op_read;
                            w_state_next  = S_TA;
                        end else begin
                            w_state_next  = S_SKIP;
                        end
                    end else begin
                        w_bit_next = r_bit_cnt + 5'd1;
                    end
                end
                S_TA: begin
                    if (r_bit_cnt == 5'd0) begin
                        w_bit_next = 5'd1;
                    end else begin
                        w_bit_next = 5'd0;
                        if (r_op_read) begin
                            // Responder drives the 0 half of turnaround
                            w_mdo_en_next = 1'b1;
                            w_mdo_next    = 1'b0;
                            w_state_next  = S_RDATA;
                        end else begin
                            w_state_next  = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (r_bit_cnt == 5'd16) begin
                        w_mdo_en_next = 1'b0;
                        w_mdo_next    = 1'b0;
                        w_pre_next    = 6'd0;
                        w_bit_next    = 5'd0;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_mdo_next = r_tx[15];
                        w_tx_next  = {r_tx[14:0], 1'b0};
                        w_bit_next = r_bit_cnt + 5'd1;
                    end
                end
                S_WDATA: begin
                    w_sh_next = {r_sh[13:0], w_bit};
                    if (r_bit_cnt == 5'd15) begin
                        w_wdata_next  = {r_sh, w_bit};
                        w_wr_stb_next = 1'b1;
                        w_bit_next    = 5'd0;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_bit_next = r_bit_cnt + 5'd1;
                    end
                end
                S_SKIP: begin
                    // Two turnaround bits plus sixteen data bits of a foreign frame
                    if (r_bit_cnt == 5'd17) begin
                        w_bit_next   = 5'd0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_bit_next = r_bit_cnt + 5'd1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_responder
//  Description : Scoreboard bench for mdio_responder. Frame tasks push the
//                expected strobes/read words; monitors pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_responder;

    localparam logic [1:0] K_RD   = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam logic [1:0] K_WORD = 2'd3;
    localparam int         NO_ABORT = 99;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  addr;
        logic [15:0] data;
        logic [4:0]  cnt;
    } ev_t;

    logic        clk_25mhz = 1'b0;
    logic        reset_n   = 1'b0;
    logic        mdc       = 1'b0;
    logic        mdi       = 1'b1;
    logic        mdo, mdo_en;
    logic [4:0]  reg_addr;
    logic        reg_rd_stb, reg_wr_stb, frame_err;
    logic [15:0] reg_rdata = 16'h0000;
    logic [15:0] reg_wdata;
    logic [15:0] rd_value  = 16'h0000;

    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];

    mdio_responder #(
        .PHY_ADDR     (5'd1),
        .BCAST_EN     (1'b1),
        .PREAMBLE_LEN (32)
    ) dut (
        .clk_25mhz  (clk_25mhz),
        .reset_n    (reset_n),
        .mdc        (mdc),
        .mdi        (mdi),
        .mdo        (mdo),
        .mdo_en     (mdo_en),
        .reg_addr   (reg_addr),
        .reg_rd_stb (reg_rd_stb),
        .reg_rdata  (reg_rdata),
        .reg_wr_stb (reg_wr_stb),
        .reg_wdata  (reg_wdata),
        .frame_err  (frame_err)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    // Register bank model: registered read data one clock after the strobe
    always @(posedge clk_25mhz) begin
        if (reg_rd_stb) reg_rdata <= rd_value;
    end

    function automatic ev_t mk(input logic [1:0] k, input logic [4:0] a,
                               input logic [15:0] d, input logic [4:0] c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.cnt = c;
        return e;
    endfunction

    function automatic string kname(input logic [1:0] k);
        case (k)
            K_RD:    return "rd_stb";
            K_WR:    return "wr_stb";
            K_ERR:   return "frame_err";
            default: return "rd_word";
        endcase
    endfunction

    task automatic check_ev(input ev_t got);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s unexpected: got addr=%0d data=%h cnt=%0d, required no event",
                     kname(got.kind), got.addr, got.data, got.cnt);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got %s addr=%0d data=%h cnt=%0d, required %s addr=%0d data=%h cnt=%0d",
                         kname(e.kind), kname(got.kind), got.addr, got.data, got.cnt,
                         kname(e.kind), e.addr, e.data, e.cnt);
            end
        end
    endtask

    // Strobe / error monitor
    initial begin
        forever begin
            @(negedge clk_25mhz);
            if (reset_n) begin
                if (reg_rd_stb || reg_wr_stb) begin
                    total++;
                    if (reg_rd_stb && reg_wr_stb) begin
                        bad++;
                        $display("FAIL strobe_excl: got rd=1 wr=1, required at most one");
                    end
                end
                if (reg_rd_stb) check_ev(mk(K_RD, reg_addr, 16'h0000, 5'd0));
                if (reg_wr_stb) check_ev(mk(K_WR, reg_addr, reg_wdata, 5'd0));
                if (frame_err)  check_ev(mk(K_ERR, 5'd0, 16'h0000, 5'd0));
            end
        end
    end

    // Serial read-data monitor, sampled on MDC fall
    initial begin
        logic        active;
        int          cnt;
        logic [15:0] word;
        active = 1'b0;
        cnt    = 0;
        word   = 16'h0000;
        forever begin
            @(negedge mdc);
            if (mdo_en) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    word   = 16'h0000;
                    total++;
                    if (mdo !== 1'b0) begin
                        bad++;
                        $display("FAIL ta_drive: got mdo=%b, required 0", mdo);
                    end
                end else begin
                    word = {word[14:0], mdo};
                    cnt++;
                end
            end else if (active) begin
                active = 1'b0;
                check_ev(mk(K_WORD, 5'd0, word, 5'(cnt)));
            end
        end
    end

    task automatic send_bit(input logic b);
        mdi = b;
        repeat (4) @(negedge clk_25mhz);
        mdc = 1'b1;
        repeat (4) @(negedge clk_25mhz);
        mdc = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic frame_hdr(input int pre, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] ra);
        repeat (pre) send_bit(1'b1);
        send_bits(32'b01, 2);
        send_bits({30'd0, op}, 2);
        send_bits({27'd0, phy}, 5);
        send_bits({27'd0, ra}, 5);
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra,
                              input logic [15:0] data, input bit hit,
                              input int abort_bit, input logic [15:0] part_word);
        rd_value = data;
        if (hit) begin
            exp_q.push_back(mk(K_RD, ra, 16'h0000, 5'd0));
            if (abort_bit == NO_ABORT) exp_q.push_back(mk(K_WORD, 5'd0, data, 5'd16));
            else                       exp_q.push_back(mk(K_WORD, 5'd0, part_word, 5'(abort_bit)));
        end
        frame_hdr(32, 2'b10, phy, ra);
        send_bit(1'b1);
        send_bit(1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == abort_bit) begin
                mdi = 1'b1;
                repeat (4) @(negedge clk_25mhz);
                mdc = 1'b1;
                repeat (3) @(negedge clk_25mhz);
                reset_n = 1'b0;
                @(negedge clk_25mhz);
                total++;
                if (mdo_en !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_release: got mdo_en=%b, required 0", mdo_en);
                end
                reset_n = 1'b1;
                @(negedge clk_25mhz);
                mdc = 1'b0;
                break;
            end
            send_bit(1'b1);
        end
        // Extra 0 bit releases the line; harmless to an idle responder
        if (abort_bit == NO_ABORT) send_bit(1'b0);
    endtask

    task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                               input logic [15:0] data, input bit hit);
        if (hit) exp_q.push_back(mk(K_WR, ra, data, 5'd0));
        frame_hdr(pre, 2'b01, phy, ra);
        send_bits(32'b10, 2);
        send_bits({16'd0, data}, 16);
    endtask

    initial begin
        repeat (5) @(negedge clk_25mhz);
        total++;
        if ({mdo, mdo_en, reg_addr, reg_rd_stb, reg_wr_stb, reg_wdata, frame_err} !== 26'd0) begin
            bad++;
            $display("FAIL reset_state: got mdo=%b mdo_en=%b addr=%0d rd=%b wr=%b wdata=%h err=%b, required all 0",
                     mdo, mdo_en, reg_addr, reg_rd_stb, reg_wr_stb, reg_wdata, frame_err);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk_25mhz);

        // Read hit
        read_frame(5'd1, 5'd3, 16'hA5C3, 1'b1, NO_ABORT, 16'h0000);
        // Write hit
        write_frame(32, 5'd1, 5'd4, 16'h1234, 1'b1);
        // Address miss, then a valid read
        read_frame(5'd2, 5'd5, 16'hFFFF, 1'b0, NO_ABORT, 16'h0000);
        read_frame(5'd1, 5'd6, 16'h5A3C, 1'b1, NO_ABORT, 16'h0000);
        // Broadcast write accepted, broadcast read ignored
        write_frame(32, 5'd0, 5'd7, 16'hBEEF, 1'b1);
        read_frame(5'd0, 5'd8, 16'h1111, 1'b0, NO_ABORT, 16'h0000);
        // Short preamble: whole frame ignored
        write_frame(31, 5'd1, 5'd9, 16'h0F0F, 1'b0);
        // Illegal OP=11
        exp_q.push_back(mk(K_ERR, 5'd0, 16'h0000, 5'd0));
        repeat (32) send_bit(1'b1);
        send_bits(32'b01, 2);
        send_bits(32'b11, 2);
        // Reset during data bit 7: first seven bits of A5C3 are 1010010
        read_frame(5'd1, 5'd10, 16'hA5C3, 1'b1, 7, 16'h0052);
        // Full read after the reset
        read_frame(5'd1, 5'd11, 16'hC3A5, 1'b1, NO_ABORT, 16'h0000);

        repeat (50) @(negedge clk_25mhz);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_empty: got %0d pending events, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
